// File: rtl/trigger_dispatcher_pkg.sv
// Shared encodings and constants for the trigger dispatcher.
package trigger_dispatcher_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SEND = 3'b010,
    DEAD = 3'b100
  } state_t;

  localparam logic [1:0] CMD_HDR = 2'b11;
  localparam int         CMD_LEN = 4;
  localparam int         TAG_W   = 2;

  function automatic logic [TAG_W-1:0] nextTag(input logic [TAG_W-1:0] tag);
    return tag + TAG_W'(1);
  endfunction

endpackage

// File: rtl/trigger_dispatcher_if.sv
// Trigger-side inputs and front-end/monitoring outputs of the dispatcher.
interface trigger_dispatcher_if #(parameter int CNTW = 16);
  import trigger_dispatcher_pkg::*;

  logic             TrgPls;
  logic             RunInProg;
  logic             EvtDone;
  logic [7:0]       DeadTime;
  logic             TrgCmd;
  logic [TAG_W-1:0] TrgTag;
  logic             Busy;
  logic [2:0]       NPend;
  logic [CNTW-1:0]  NTrgAcc;
  logic [CNTW-1:0]  NTrgRej;
  logic             ErrUnder;

  modport master (
    output TrgPls, RunInProg, EvtDone, DeadTime,
    input  TrgCmd, TrgTag, Busy, NPend, NTrgAcc, NTrgRej, ErrUnder
  );

  modport slave (
    input  TrgPls, RunInProg, EvtDone, DeadTime,
    output TrgCmd, TrgTag, Busy, NPend, NTrgAcc, NTrgRej, ErrUnder
  );

endinterface

// File: rtl/trigger_dispatcher_sat_counter.sv
// Saturating up-counter with synchronous clear, used for monitoring counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Cnt
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Cnt <= '0;
    end else if (Clr) begin
      Cnt <= '0;
    end else if (Inc && (Cnt != '1)) begin
      Cnt <= Cnt + W'(1);
    end
  end

endmodule

// File: rtl/trigger_dispatcher.sv
// Accepts/rejects trigger pulses, serialises accepted ones as tagged commands
// and tracks outstanding events for throttling.
module trigger_dispatcher
  import trigger_dispatcher_pkg::*;
#(
  parameter int MAXPEND = 4,
  parameter int CNTW    = 16
) (
  input logic                 Clock,
  input logic                 Reset,
  trigger_dispatcher_if.slave bus
);

  state_t           state, stateNext;
  logic             runPrev;
  logic [3:0]       shReg;
  logic [1:0]       bitCnt;
  logic [7:0]       deadCnt;
  logic [TAG_W-1:0] tagNext;
  logic             runStart, accept, reject;

  assign runStart   = bus.RunInProg & ~runPrev;
  assign bus.Busy   = (state != IDLE) | (bus.NPend == 3'(MAXPEND)) | ~bus.RunInProg;
  assign accept     = bus.TrgPls & bus.RunInProg & ~bus.Busy & ~runStart;
  assign reject     = bus.TrgPls & bus.RunInProg & bus.Busy & ~runStart;
  assign tagNext    = nextTag(bus.TrgTag);
  // Gated by state so an asynchronous reset silences the line immediately.
  assign bus.TrgCmd = (state == SEND) & shReg[3];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = SEND;
      SEND:    if (bitCnt == 2'(CMD_LEN - 1))
                 stateNext = (bus.DeadTime != 8'd0) ? DEAD : IDLE;
      DEAD:    if (deadCnt == 8'd0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (runStart) stateNext = IDLE;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      runPrev      <= 1'b0;
      shReg        <= '0;
      bitCnt       <= '0;
      deadCnt      <= '0;
      bus.TrgTag   <= '0;
      bus.NPend    <= '0;
      bus.ErrUnder <= 1'b0;
    end else begin
      runPrev <= bus.RunInProg;
      if (runStart) begin
        bus.TrgTag   <= '0;
        bus.NPend    <= '0;
        bus.ErrUnder <= 1'b0;
        bitCnt       <= '0;
      end else begin
        if (accept) begin
          shReg      <= {CMD_HDR, tagNext};
          bus.TrgTag <= tagNext;
          bitCnt     <= '0;
        end else if (state == SEND) begin
          shReg  <= {shReg[2:0], 1'b0};
          bitCnt <= bitCnt + 2'd1;
        end

        // Counter holds DeadTime-1 on entry so DEAD lasts exactly DeadTime clocks.
        if ((state == SEND) && (stateNext == DEAD)) deadCnt <= bus.DeadTime - 8'd1;
        else if ((state == DEAD) && (deadCnt != 8'd0)) deadCnt <= deadCnt - 8'd1;

        if (accept && !bus.EvtDone) begin
          bus.NPend <= bus.NPend + 3'd1;
        end else if (!accept && bus.EvtDone) begin
          if (bus.NPend == 3'd0) bus.ErrUnder <= 1'b1;
          else                   bus.NPend    <= bus.NPend - 3'd1;
        end
      end
    end
  end

  sat_counter #(.W(CNTW)) uAccCnt (
    .Clock (Clock),
    .Reset (Reset),
    .Clr   (runStart),
    .Inc   (accept),
    .Cnt   (bus.NTrgAcc)
  );

  sat_counter #(.W(CNTW)) uRejCnt (
    .Clock (Clock),
    .Reset (Reset),
    .Clr   (runStart),
    .Inc   (reject),
    .Cnt   (bus.NTrgRej)
  );

endmodule
